// File: rtl/ram_pkg.sv
// Shared constants, address split helpers and clear-sequencer state for banked_ram.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ram_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_BANKS  = 4;

  // Bank index is the low bank_bits of the word address (0 bits -> always bank 0).
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bits);
    return addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  // Row inside a bank is whatever remains above the bank bits.
  function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bits);
    return addr >> bank_bits;
  endfunction

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

endpackage

// File: rtl/ram_bank.sv
// Single-port synchronous RAM bank: one read or one write per enabled cycle.
// Latency: read data registered, valid the cycle after the enabled read edge.
// Backpressure: none; always accepts when en is high, rdata holds otherwise.
module ram_bank #(
  parameter int ROW_W      = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_W-1:0]      row,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ROW_W)-1];

  // Storage array and registered read port; rdata only moves on a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[row] <= wdata;
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/banked_ram.sv
// Dual-port banked RAM; port A has fixed priority on a bank conflict. Optional
// post-reset zero-fill when RAM_INIT_CLEAR_EN is defined.
// Latency: 1 cycle from accepted read to rvalid/rdata; backpressure via ready (B stalls on conflict, both stall during clear).
module banked_ram
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  init_busy
);

  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;

  logic [BANK_W-1:0]     a_bank, b_bank, a_bank_q, b_bank_q;
  logic [ROW_W-1:0]      a_row, b_row, clr_row;
  logic                  a_acc, b_acc, clr_active;
  logic [DATA_WIDTH-1:0] a_hold, b_hold;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  assign a_bank = BANK_W'(bank_of(32'(a_addr), BANK_BITS));
  assign b_bank = BANK_W'(bank_of(32'(b_addr), BANK_BITS));
  assign a_row  = ROW_W'(row_of(32'(a_addr), BANK_BITS));
  assign b_row  = ROW_W'(row_of(32'(b_addr), BANK_BITS));

`ifdef RAM_INIT_CLEAR_EN
  clr_state_t       state_q, state_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;

  // Sequencer state and row counter; reset always restarts the fill at row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
    end
  end

  // Walk every row once, then hand the array over to the ports.
  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    if (state_q == CLEAR) begin
      clr_row_d = clr_row_q + 1'b1;
      if (clr_row_q == {ROW_W{1'b1}}) state_d = RUN;
    end
  end

  // While clearing, all banks are owned by the sequencer.
  always_comb begin
    clr_active = (state_q == CLEAR);
    clr_row    = clr_row_q;
  end
`else
  assign clr_active = 1'b0;
  assign clr_row    = '0;
`endif

  assign init_busy = clr_active;
  assign a_ready   = !clr_active && !rst;
  assign b_ready   = a_ready && !(a_req && (a_bank == b_bank));
  assign a_acc     = a_req && a_ready;
  assign b_acc     = b_req && b_ready;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic                  en, we;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] wd;

    // Per-bank port select: sequencer, then A, then B.
    always_comb begin
      en  = 1'b0;
      we  = 1'b0;
      row = a_row;
      wd  = a_wdata;
      if (clr_active) begin
        en  = 1'b1;
        we  = 1'b1;
        row = clr_row;
        wd  = '0;
      end else if (a_acc && (a_bank == BANK_W'(i))) begin
        en = 1'b1;
        we = a_we;
      end else if (b_acc && (b_bank == BANK_W'(i))) begin
        en  = 1'b1;
        we  = b_we;
        row = b_row;
        wd  = b_wdata;
      end
    end

    ram_bank #(
      .ROW_W      (ROW_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk   (clk),
      .en    (en),
      .we    (we),
      .row   (row),
      .wdata (wd),
      .rdata (bank_rdata[i])
    );
  end

  // Response pipeline: remember which bank answers, and latch each result so
  // rdata stays put after the bank is reused by the other port.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_bank_q <= '0;
      b_bank_q <= '0;
      a_hold   <= '0;
      b_hold   <= '0;
    end else begin
      a_rvalid <= a_acc && !a_we;
      b_rvalid <= b_acc && !b_we;
      if (a_acc && !a_we) a_bank_q <= a_bank;
      if (b_acc && !b_we) b_bank_q <= b_bank;
      if (a_rvalid) a_hold <= a_rdata;
      if (b_rvalid) b_hold <= b_rdata;
    end
  end

  assign a_rdata = a_rvalid ? bank_rdata[a_bank_q] : a_hold;
  assign b_rdata = b_rvalid ? bank_rdata[b_bank_q] : b_hold;

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram: reset, clear timing, parallel access, conflict,
// read-after-write, streaming, reset-drop. Clear checks adapt to RAM_INIT_CLEAR_EN.
module tb_banked_ram;

`ifdef RAM_INIT_CLEAR_EN
  localparam int CLR_CYC = 2048;
  localparam logic BUSY_RST = 1'b1;
`else
  localparam int CLR_CYC = 0;
  localparam logic BUSY_RST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [12:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, a_rvalid, b_ready, b_rvalid, init_busy;
  logic [7:0] a_rdata, b_rdata;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  banked_ram dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_busy(init_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [12:0] ad, input logic [7:0] wd);
    a_req = req; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [12:0] ad, input logic [7:0] wd);
    b_req = req; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  // Count edges from now until a_ready rises, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!a_ready && cnt < 5000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    repeat (3) tick();
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_init_busy", init_busy, BUSY_RST);

    tick();
    rst = 1'b0;
    #1;
    wait_ready(n);
    check("clear_cycles", n, CLR_CYC);
    check("post_clear_busy", init_busy, 0);
    check("post_clear_b_ready", b_ready, 1);

`ifdef RAM_INIT_CLEAR_EN
    drive_a(1, 0, 13'h1FFF, 0);
    tick();
    drive_a(0, 0, 0, 0);
    #1;
    check("clr_rvalid", a_rvalid, 1);
    check("clr_rdata_1fff", a_rdata, 8'h00);
`endif

    // Parallel writes to banks 0 and 1.
    drive_a(1, 1, 13'h0004, 8'h5A);
    drive_b(1, 1, 13'h0005, 8'hA5);
    #1;
    check("par_wr_a_ready", a_ready, 1);
    check("par_wr_b_ready", b_ready, 1);
    tick();
    drive_a(1, 0, 13'h0004, 0);
    drive_b(1, 0, 13'h0005, 0);
    #1;
    check("wr_no_a_rvalid", a_rvalid, 0);
    check("wr_no_b_rvalid", b_rvalid, 0);
    check("par_rd_b_ready", b_ready, 1);
    tick();
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    #1;
    check("par_rd_a_rvalid", a_rvalid, 1);
    check("par_rd_a_rdata", a_rdata, 8'h5A);
    check("par_rd_b_rvalid", b_rvalid, 1);
    check("par_rd_b_rdata", b_rdata, 8'hA5);

    // Same-address reads always conflict.
    drive_a(1, 0, 13'h0004, 0);
    drive_b(1, 0, 13'h0004, 0);
    #1;
    check("same_addr_b_ready", b_ready, 0);
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);

    // Seed bank 0 rows for the conflict test.
    drive_a(1, 1, 13'h0008, 8'h11);
    tick();
    drive_a(1, 1, 13'h0010, 8'h22);
    tick();

    // Conflict: both read bank 0, A wins, B holds its request.
    drive_a(1, 0, 13'h0008, 0);
    drive_b(1, 0, 13'h0010, 0);
    #1;
    check("cf_c0_a_ready", a_ready, 1);
    check("cf_c0_b_ready", b_ready, 0);
    tick();
    drive_a(0, 0, 0, 0);
    #1;
    check("cf_c1_a_rvalid", a_rvalid, 1);
    check("cf_c1_a_rdata", a_rdata, 8'h11);
    check("cf_c1_b_ready", b_ready, 1);
    check("cf_c1_b_rvalid", b_rvalid, 0);
    tick();
    drive_b(0, 0, 0, 0);
    #1;
    check("cf_c2_b_rvalid", b_rvalid, 1);
    check("cf_c2_b_rdata", b_rdata, 8'h22);
    check("cf_c2_a_rvalid", a_rvalid, 0);
    check("cf_c2_a_hold", a_rdata, 8'h11);

    // Write then read the same address back to back.
    drive_a(1, 1, 13'h0100, 8'h33);
    tick();
    drive_a(1, 0, 13'h0100, 0);
    #1;
    check("raw_b_hold", b_rdata, 8'h22);
    tick();
    drive_a(0, 0, 0, 0);
    #1;
    check("raw_rvalid", a_rvalid, 1);
    check("raw_rdata", a_rdata, 8'h33);

    // Fill 0x200..0x20F then stream reads one per cycle.
    for (int i = 0; i < 16; i++) begin
      drive_a(1, 1, 13'h0200 + 13'(i), 8'(i) ^ 8'h5C);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive_a(1, 0, 13'h0200 + 13'(i), 0);
      tick();
      #1;
      check($sformatf("stream_rvalid_%0d", i), a_rvalid, 1);
      check($sformatf("stream_rdata_%0d", i), a_rdata, 8'(i) ^ 8'h5C);
    end
    drive_a(0, 0, 0, 0);
    tick();
    check("stream_end_rvalid", a_rvalid, 0);
    check("stream_end_hold", a_rdata, 8'h5C ^ 8'h0F);

    // A read presented while rst rises is dropped.
    drive_a(1, 0, 13'h0004, 0);
    rst = 1'b1;
    #1;
    check("rstdrop_a_ready", a_ready, 0);
    tick();
    drive_a(0, 0, 0, 0);
    #1;
    check("rstdrop_rvalid", a_rvalid, 0);
    check("rstdrop_rdata", a_rdata, 0);
    tick();
    rst = 1'b0;
    #1;

`ifdef RAM_INIT_CLEAR_EN
    // Restart the clear part-way through.
    repeat (100) tick();
    check("midclr_busy", init_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
`endif
    wait_ready(n);
    check("reclear_cycles", n, CLR_CYC);

    // Contents survive rst unless the clear sequencer wipes them.
    drive_a(1, 0, 13'h0004, 0);
    tick();
    drive_a(0, 0, 0, 0);
    #1;
    check("post_rst_rvalid", a_rvalid, 1);
`ifdef RAM_INIT_CLEAR_EN
    check("post_rst_rdata", a_rdata, 8'h00);
`else
    check("post_rst_rdata", a_rdata, 8'h5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
